// File: rtl/memstore_buffer.sv
`default_nettype none
// ============================================================================
// Module   : memstore_buffer
// Purpose  : Store buffer between MEM and the data bus. It turns stores into
//            strobes and lane-replicated data, queues them, and drains them
//            one at a time over req/addr_ok/data_ok.
//            Optional macro STORE_MISALIGN_EXC_EN raises st_ades on a
//            misaligned store. Without it, the store is force-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module memstore_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [WIDTH-1:0] st_addr,
    input  logic [WIDTH-1:0] st_data,
    input  logic [3:0]       st_width,
    output logic             st_ades,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [WIDTH-1:0] data_addr,
    output logic [3:0]       data_wstrb,
    output logic [WIDTH-1:0] data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    output logic             sb_empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 * WIDTH + 6;

    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ZERO = '0;
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;

    logic               w_codeOk;
    logic [1:0]         w_size;
    logic [WIDTH-1:0]   w_wdata;
    logic [WIDTH-1:0]   w_alignAddr;
    logic [3:0]         w_wstrb;
    logic [ENTRY_W-1:0] w_enqEntry;
    logic               w_accept;
    logic               w_enq;
    logic               w_pop;
    logic               w_load;
    logic [ENTRY_W-1:0] w_loadEntry;
    logic [PTR_W-1:0]   w_rdNext;
    logic               w_idleAvail;
    logic               w_waitMore;
    logic               w_waitAvail;

    assign st_ready = (r_count != c_FULL);
    assign w_accept = st_valid && st_ready;
    assign data_wr  = 1'b1;

    always_comb begin
        w_codeOk = 1'b1;
        w_size   = 2'd0;
        w_wdata  = st_data;
        case (st_width)
            4'b0001: begin
                w_size  = 2'd0;
                w_wdata = {4{st_data[7:0]}};
            end
            4'b0011: begin
                w_size  = 2'd1;
                w_wdata = {2{st_data[15:0]}};
            end
            4'b1111: begin
                w_size  = 2'd2;
                w_wdata = st_data;
            end
            default: w_codeOk = 1'b0;
        endcase
    end

`ifdef STORE_MISALIGN_EXC_EN
    logic w_misalign;
    assign w_misalign  = ((w_size == 2'd1) && st_addr[0]) ||
                         ((w_size == 2'd2) && (st_addr[1:0] != 2'b00));
    assign st_ades     = st_valid && w_codeOk && w_misalign;
    assign w_alignAddr = st_addr;
    assign w_enq       = w_accept && w_codeOk && !w_misalign;
`else
    assign st_ades     = 1'b0;
    // Clear the low address bits that a half or word access must not use.
    assign w_alignAddr = {st_addr[WIDTH-1:2],
                          st_addr[1] & (w_size != 2'd2),
                          st_addr[0] & (w_size == 2'd0)};
    assign w_enq       = w_accept && w_codeOk;
`endif

    assign w_wstrb    = st_width << w_alignAddr[1:0];
    assign w_enqEntry = {w_alignAddr, w_size, w_wstrb, w_wdata};

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wrPtr] <= w_enqEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdNext;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_rdNext = r_rdPtr + 1'b1;
    // A store arriving this cycle counts as a queued head, so it is forwarded.
    assign w_idleAvail = (r_count != c_ZERO) || w_enq;
    assign w_waitMore  = (r_count > c_ONE);
    assign w_waitAvail = w_waitMore || w_enq;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: if (w_idleAvail) w_stateNext = c_REQ;
            c_REQ:  if (data_addr_ok) w_stateNext = data_data_ok ? c_IDLE : c_WAIT;
            c_WAIT: if (data_data_ok) w_stateNext = w_waitAvail ? c_REQ : c_IDLE;
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_loadEntry = r_mem[r_rdPtr];
        case (r_state)
            c_IDLE: begin
                w_load      = w_idleAvail;
                w_loadEntry = (r_count != c_ZERO) ? r_mem[r_rdPtr] : w_enqEntry;
            end
            c_REQ: begin
                w_pop = data_addr_ok && data_data_ok;
            end
            c_WAIT: begin
                w_pop       = data_data_ok;
                w_load      = data_data_ok && w_waitAvail;
                w_loadEntry = w_waitMore ? r_mem[w_rdNext] : w_enqEntry;
            end
            default: ;
        endcase
        data_req = (r_state == c_REQ);
        sb_empty = (r_count == c_ZERO) && (r_state == c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_addr  <= '0;
            data_size  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
        end else if (w_load) begin
            {data_addr, data_size, data_wstrb, data_wdata} <= w_loadEntry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memstore_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_memstore_buffer
// Purpose  : Directed self-checking bench for memstore_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memstore_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_width;
    logic        st_ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        sb_empty;

    int checkCount = 0;
    int failCount  = 0;

    memstore_buffer #(.DEPTH(4), .WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_width     (st_width),
        .st_ades      (st_ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .sb_empty     (sb_empty)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_width = w;
        step();
        st_valid = 1'b0;
    endtask

    task automatic busDone();
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_width = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        step(); step();
        checkVal("rst_req",   {31'd0, data_req},   32'd0);
        checkVal("rst_empty", {31'd0, sb_empty},   32'd1);
        checkVal("rst_ready", {31'd0, st_ready},   32'd1);
        checkVal("rst_addr",  data_addr,           32'd0);
        checkVal("rst_strb",  {28'd0, data_wstrb}, 32'd0);
        checkVal("rst_wdata", data_wdata,          32'd0);
        checkVal("rst_ades",  {31'd0, st_ades},    32'd0);
        checkVal("wr_const",  {31'd0, data_wr},    32'd1);
        resetn = 1'b1;
        step();

        // Byte store into empty buffer
        doStore(32'h0000_1003, 32'h0000_00A5, 4'b0001);
        checkVal("b_req",   {31'd0, data_req},   32'd1);
        checkVal("b_addr",  data_addr,           32'h0000_1003);
        checkVal("b_strb",  {28'd0, data_wstrb}, 32'h8);
        checkVal("b_wdata", data_wdata,          32'hA5A5_A5A5);
        checkVal("b_size",  {30'd0, data_size},  32'd0);
        checkVal("b_empty", {31'd0, sb_empty},   32'd0);
        busDone();
        checkVal("b_done_empty", {31'd0, sb_empty}, 32'd1);
        checkVal("b_done_req",   {31'd0, data_req}, 32'd0);

        // Half store with addr_ok stall
        doStore(32'h0000_2002, 32'h1234_BEEF, 4'b0011);
        checkVal("h_strb",  {28'd0, data_wstrb}, 32'hC);
        checkVal("h_wdata", data_wdata,          32'hBEEF_BEEF);
        checkVal("h_size",  {30'd0, data_size},  32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("h_stall_req",  {31'd0, data_req}, 32'd1);
            checkVal("h_stall_addr", data_addr,         32'h0000_2002);
        end
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
        checkVal("h_wait_req", {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1; step(); data_data_ok = 1'b0;
        checkVal("h_done_empty", {31'd0, sb_empty}, 32'd1);

        // Fill with bus stalled
        for (int i = 0; i < 4; i++) begin
            doStore(32'h100 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 4'b1111);
        end
        checkVal("f_full_ready", {31'd0, st_ready}, 32'd0);
        checkVal("f_head_addr",  data_addr,         32'h100);
        busDone();
        checkVal("f_pop_ready", {31'd0, st_ready}, 32'd1);
        checkVal("f_pop_req",   {31'd0, data_req}, 32'd0);
        step();
        checkVal("f_e1_addr", data_addr, 32'h104);
        checkVal("f_e1_req",  {31'd0, data_req}, 32'd1);
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; step(); data_data_ok = 1'b0;
        checkVal("f_e2_addr", data_addr, 32'h108);
        checkVal("f_e2_req",  {31'd0, data_req}, 32'd1);
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; step(); data_data_ok = 1'b0;
        checkVal("f_e3_addr",  data_addr,  32'h10C);
        checkVal("f_e3_wdata", data_wdata, 32'h4444_4444);
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
        // Completion and new store on the same edge: new store issues next
        data_data_ok = 1'b1;
        doStore(32'h300, 32'h0BAD_F00D, 4'b1111);
        data_data_ok = 1'b0;
        checkVal("f_fwd_req",  {31'd0, data_req}, 32'd1);
        checkVal("f_fwd_addr", data_addr,         32'h300);
        busDone();
        checkVal("f_done_empty", {31'd0, sb_empty}, 32'd1);

        // Misaligned word
        st_valid = 1'b1; st_addr = 32'h3001; st_data = 32'hCAFE_F00D; st_width = 4'b1111;
        #1;
`ifdef STORE_MISALIGN_EXC_EN
        checkVal("m_ades", {31'd0, st_ades}, 32'd1);
        step(); st_valid = 1'b0;
        checkVal("m_empty", {31'd0, sb_empty}, 32'd1);
        checkVal("m_req",   {31'd0, data_req}, 32'd0);
`else
        checkVal("m_ades", {31'd0, st_ades}, 32'd0);
        step(); st_valid = 1'b0;
        checkVal("m_addr", data_addr,           32'h3000);
        checkVal("m_strb", {28'd0, data_wstrb}, 32'hF);
        busDone();
`endif

        // Invalid width code is consumed and dropped
        doStore(32'h3100, 32'h1, 4'b0111);
        checkVal("inv_empty", {31'd0, sb_empty}, 32'd1);
        checkVal("inv_req",   {31'd0, data_req}, 32'd0);

        // Reset while waiting with two entries queued
        doStore(32'h400, 32'h4, 4'b1111);
        doStore(32'h404, 32'h5, 4'b1111);
        data_addr_ok = 1'b1; step(); data_addr_ok = 1'b0;
        resetn = 1'b0; step(); resetn = 1'b1;
        checkVal("r_req",   {31'd0, data_req}, 32'd0);
        checkVal("r_empty", {31'd0, sb_empty}, 32'd1);
        data_data_ok = 1'b1; step(); data_data_ok = 1'b0;
        checkVal("r_late_req",   {31'd0, data_req}, 32'd0);
        checkVal("r_late_empty", {31'd0, sb_empty}, 32'd1);
        step();
        checkVal("r_late_req2", {31'd0, data_req}, 32'd0);

        // addr_ok and data_ok together with two entries
        doStore(32'h500, 32'h55, 4'b0001);
        doStore(32'h502, 32'hABCD, 4'b0011);
        busDone();
        checkVal("s_gap_req",   {31'd0, data_req}, 32'd0);
        checkVal("s_gap_empty", {31'd0, sb_empty}, 32'd0);
        step();
        checkVal("s_e2_req",   {31'd0, data_req},   32'd1);
        checkVal("s_e2_addr",  data_addr,           32'h502);
        checkVal("s_e2_strb",  {28'd0, data_wstrb}, 32'hC);
        checkVal("s_e2_wdata", data_wdata,          32'hABCD_ABCD);
        busDone();
        checkVal("s_done_empty", {31'd0, sb_empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memstore_buffer.md
# memstore_buffer

Store-side counterpart of the load path. Accepts store requests from the memory stage, converts address, width and register data into byte strobes and lane-replicated write data, and queues them in a small FIFO. It drains the FIFO one transaction at a time to the data-side SRAM-like bus using a `req`/`addr_ok`/`data_ok` handshake. The block sits between the MEM stage and the data cache/bridge, and exposes an empty flag so loads can stall behind pending stores.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, minimum 2.
- `WIDTH`, 32: address/data width. Only 32 is supported.

- `clk` input 1: clock.
- `resetn` input 1: reset. Synchronous and active-low.
- `st_valid` input 1: store request valid.
- `st_ready` output 1: buffer can accept a store (`!full`).
- `st_addr` input 32: byte address.
- `st_data` input 32: register data. The store value is in the low bits.
- `st_width` input 4: 4'b1111 word, 4'b0011 half, 4'b0001 byte.
- `st_ades` output 1: misaligned-store exception. Only meaningful with the macro; see Configuration.
- `data_req` output 1: bus request.
- `data_wr` output 1: constant 1.
- `data_size` output 2: 0 byte, 1 half, 2 word.
- `data_addr` output 32: store address.
- `data_wstrb` output 4: byte strobes.
- `data_wdata` output 32: lane-replicated data.
- `data_addr_ok` input 1: address accepted.
- `data_data_ok` input 1: write completed.
- `sb_empty` output 1: FIFO empty and no transaction in flight.

## Operation
- Enqueue happens on the rising edge when `st_valid && st_ready`. The entry stores {addr, size, wstrb, wdata}.
- Strobe: `wstrb = st_width << st_addr[1:0]`.
- Data replication:
  - byte: {4{st_data[7:0]}}
  - half: {2{st_data[15:0]}}
  - word: st_data
- Invalid `st_width` code: the request is consumed (`st_ready` honoured), but nothing is enqueued and `st_ades` stays 0.
- Misalignment definition:
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
- Drain FSM:
  - IDLE: if the FIFO is non-empty, latch the head into the output registers and go to REQ.
  - REQ: `data_req`=1 and outputs held stable.
    - On `data_addr_ok`: go to WAIT, or, if `data_data_ok` is also high the same cycle, pop the head and go to IDLE.
  - WAIT: `data_req`=0.
    - On `data_data_ok`: pop the head, then go to REQ with the next head latched if the FIFO stays non-empty; otherwise go to IDLE.
- At most one outstanding transaction.
- `data_data_ok` is ignored outside WAIT/REQ.
- `sb_empty` = (count==0) && state==IDLE.

## Timing
- Reset values:
  - `data_req`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`, `st_ades` are 0.
  - `sb_empty`=1.
  - `st_ready`=1.
  - FIFO pointers and count are 0; FSM in IDLE.
- `st_ready` is combinational from the registered count. When full it is 0, even if a pop happens in the same cycle.
- Store accepted into an empty buffer at edge N: FSM reaches REQ and `data_req` is high in cycle N+1. `sb_empty` falls in cycle N+1.
- Simultaneous enqueue and pop: count is unchanged, and the new entry is appended after the remaining entries.
- Pointers wrap modulo `DEPTH`.
- `resetn` low mid-transaction: the FIFO is cleared and the FSM returns to IDLE on that edge. An in-flight transaction is abandoned; later `data_data_ok` pulses are ignored.
- Output fields change only on entry to REQ.

## Configuration
- `STORE_MISALIGN_EXC_EN` defined:
  - A misaligned store with `st_valid` drives `st_ades`=1 combinationally in that cycle.
  - The request is consumed but not enqueued.
- Not defined:
  - `st_ades` is tied to 0.
  - Misaligned addresses are force-aligned before enqueue: addr[1:0] cleared for word, addr[0] cleared for half. The strobe is recomputed from the aligned address.

## Test plan
- Byte store: addr 0x1003, data 0x000000A5, width 4'b0001 into an empty buffer -> next cycle `data_req`=1, `data_addr`=0x1003, `data_wstrb`=4'b1000, `data_wdata`=0xA5A5A5A5, `data_size`=0.
- Half store: addr 0x2002, data 0x1234BEEF -> `wstrb`=4'b1100, `wdata`=0xBEEFBEEF, `size`=1. Holding `addr_ok` low for 3 cycles -> outputs stable, `data_req` stays 1.
- Fill: 4 back-to-back word stores with the bus stalled -> `st_ready`=0 after the 4th. One `data_ok` -> `st_ready`=1 next cycle, and stores drain in order.
- Misaligned word at 0x3001:
  - With macro: `st_ades`=1, nothing issued, `sb_empty` stays 1.
  - Without macro: issued at 0x3000 with `wstrb`=4'b1111.
- `resetn` low while in WAIT with 2 entries queued -> next cycle `data_req`=0, `sb_empty`=1. A late `data_data_ok` causes no pop and no request.
- `addr_ok` and `data_ok` in the same cycle with 2 entries -> first entry popped, second entry requested on the following cycle.
